// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, deframes 11-bit frames and
// decodes set-2 E0/F0 prefixes into scan_code/extended/make_break with a one-cycle valid strobe.
module ps2_scan_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 75000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] scan_code,
    output logic       extended,
    output logic       make_break,
    output logic       valid,
    output logic       frame_err
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_e;

    // Input synchronizers
    logic clk_meta_q, clk_sync_q;
    logic dat_meta_q, dat_sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_dat;
            dat_sync_q <= dat_meta_q;
        end
    end

    // Glitch filter: the filtered level flips only after FILTER_LEN consecutive differing samples
    logic             filt_clk_q;
    logic             filt_prev_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic             fall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            filt_clk_q  <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_prev_q <= filt_clk_q;
            if (clk_sync_q == filt_clk_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FiltLast) begin
                filt_clk_q <= clk_sync_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall = filt_prev_q & ~filt_clk_q;

    // Frame deserializer
    state_e         state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic           parity_ok_q;
    logic [ToW-1:0] to_cnt_q;
    logic           byte_ready_q;
    logic [7:0]     byte_q;
    logic           frame_err_q;
    logic           timeout;

    // A fall strobe in the same cycle wins over an expiring timeout
    assign timeout = (state_q != StIdle) && !fall && (to_cnt_q == ToLast);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_ok_q  <= 1'b0;
            to_cnt_q     <= '0;
            byte_ready_q <= 1'b0;
            byte_q       <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (state_q == StIdle || fall) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != ToLast) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end

            if (timeout) begin
                state_q     <= StIdle;
                frame_err_q <= 1'b1;
            end else if (fall) begin
                unique case (state_q)
                    StIdle: begin
                        if (!dat_sync_q) begin
                            state_q   <= StData;
                            bit_cnt_q <= '0;
                        end
                    end
                    StData: begin
                        shift_q   <= {dat_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= StParity;
                        end
                    end
                    StParity: begin
                        parity_ok_q <= ^{shift_q, dat_sync_q};
                        state_q     <= StStop;
                    end
                    StStop: begin
                        if (dat_sync_q && parity_ok_q) begin
                            byte_ready_q <= 1'b1;
                            byte_q       <= shift_q;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign frame_err = frame_err_q;

    // Prefix decoder
    logic ext_pending_q;
    logic brk_pending_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ext_pending_q <= 1'b0;
            brk_pending_q <= 1'b0;
            scan_code     <= '0;
            extended      <= 1'b0;
            make_break    <= 1'b0;
            valid         <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (frame_err_q) begin
                ext_pending_q <= 1'b0;
                brk_pending_q <= 1'b0;
            end else if (byte_ready_q) begin
                if (byte_q == 8'hE0) begin
                    ext_pending_q <= 1'b1;
                end else if (byte_q == 8'hF0) begin
                    brk_pending_q <= 1'b1;
                end else begin
                    scan_code     <= byte_q;
                    extended      <= ext_pending_q;
                    make_break    <= ~brk_pending_q;
                    valid         <= 1'b1;
                    ext_pending_q <= 1'b0;
                    brk_pending_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Self-checking bench for ps2_scan_receiver: directed and random PS/2 frames compared against
// a frame-level model of prefix decoding, plus timeout, glitch and mid-frame reset scenarios.
module tb_ps2_scan_receiver;

    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 1500;
    localparam int unsigned HALF = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] scan_code;
    logic       extended;
    logic       make_break;
    logic       valid;
    logic       frame_err;

    ps2_scan_receiver #(
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .scan_code (scan_code),
        .extended  (extended),
        .make_break(make_break),
        .valid     (valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcount = 0;
    int ecount = 0;
    int both = 0;
    int vcyc = 0;
    int ecyc = 0;
    int fall_cyc = 0;

    // Reference model state
    logic [7:0] m_code = 8'h00;
    logic       m_ext_o = 1'b0;
    logic       m_mb = 1'b0;
    logic       m_ext_p = 1'b0;
    logic       m_brk_p = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vcount <= vcount + 1;
            vcyc   <= cyc;
        end
        if (frame_err === 1'b1) begin
            ecount <= ecount + 1;
            ecyc   <= cyc;
        end
        if (valid === 1'b1 && frame_err === 1'b1) both <= both + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Host-side view: data changes while the clock is high, device samples on the falling edge
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            if (glitch) begin
                wait_cyc(12);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(HALF - 15);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk  = 1'b0;
            fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".scan"}, 32'(scan_code), 32'(m_code));
        check({tag, ".ext"}, 32'(extended), 32'(m_ext_o));
        check({tag, ".mb"}, 32'(make_break), 32'(m_mb));
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input string tag);
        logic [10:0] bits;
        int          v0;
        int          e0;
        int          lat;
        bit          exp_v;
        bit          exp_e;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        v0   = vcount;
        e0   = ecount;
        send_bits(bits, 11, glitch);
        wait_cyc(40);
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (bad_par || bad_stop) begin
            exp_e   = 1'b1;
            m_ext_p = 1'b0;
            m_brk_p = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext_p = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk_p = 1'b1;
        end else begin
            exp_v   = 1'b1;
            m_code  = b;
            m_ext_o = m_ext_p;
            m_mb    = ~m_brk_p;
            m_ext_p = 1'b0;
            m_brk_p = 1'b0;
        end
        check({tag, ".nvalid"}, 32'(vcount - v0), 32'(exp_v));
        check({tag, ".nerr"}, 32'(ecount - e0), 32'(exp_e));
        check_outputs(tag);
        if (exp_v) begin
            lat = vcyc - fall_cyc;
            check({tag, ".latency"}, 32'(lat >= int'(FILT) + 3 && lat <= int'(FILT) + 5), 32'd1);
        end
    endtask

    initial begin
        int          v0;
        int          e0;
        int          n;
        int          k;
        logic [7:0]  b;

        // Reset state
        reset = 1'b0;
        wait_cyc(5);
        check("rst.scan", 32'(scan_code), 32'h0);
        check("rst.ext", 32'(extended), 32'h0);
        check("rst.mb", 32'(make_break), 32'h0);
        check("rst.valid", 32'(valid), 32'h0);
        check("rst.err", 32'(frame_err), 32'h0);
        reset = 1'b1;
        wait_cyc(20);

        // Directed sequences
        do_frame(8'h1C, 1'b0, 1'b0, 1'b0, "make1C");
        do_frame(8'hF0, 1'b0, 1'b0, 1'b0, "brkF0");
        do_frame(8'h1C, 1'b0, 1'b0, 1'b0, "brk1C");
        do_frame(8'hE0, 1'b0, 1'b0, 1'b0, "extE0");
        do_frame(8'h75, 1'b0, 1'b0, 1'b0, "ext75");
        do_frame(8'hE0, 1'b0, 1'b0, 1'b0, "ebE0");
        do_frame(8'hF0, 1'b0, 1'b0, 1'b0, "ebF0");
        do_frame(8'h75, 1'b0, 1'b0, 1'b0, "eb75");
        do_frame(8'h1C, 1'b0, 1'b0, 1'b0, "after1C");
        do_frame(8'hF0, 1'b0, 1'b0, 1'b0, "beF0");
        do_frame(8'hE0, 1'b0, 1'b0, 1'b0, "beE0");
        do_frame(8'h75, 1'b0, 1'b0, 1'b0, "be75");
        do_frame(8'hE0, 1'b0, 1'b0, 1'b0, "eeE0a");
        do_frame(8'hE0, 1'b0, 1'b0, 1'b0, "eeE0b");
        do_frame(8'h6B, 1'b0, 1'b0, 1'b0, "ee6B");
        do_frame(8'hF0, 1'b0, 1'b0, 1'b0, "parF0");
        do_frame(8'h1C, 1'b1, 1'b0, 1'b0, "badpar");
        do_frame(8'h29, 1'b0, 1'b0, 1'b0, "good29");
        do_frame(8'h33, 1'b0, 1'b1, 1'b0, "badstop");

        // Random frames including prefixes and corrupted frames
        for (int i = 0; i < 16; i++) begin
            k = int'($urandom_range(0, 9));
            b = 8'($urandom);
            if (k < 2) b = 8'hE0;
            else if (k < 4) b = 8'hF0;
            do_frame(b, k == 4, k == 5, 1'b0, $sformatf("rand%0d", i));
        end

        // Short low glitches on every high phase must not add bits
        do_frame(8'h5A, 1'b0, 1'b0, 1'b1, "glitch");

        // Timeout: pending E0, then start + 3 data bits and the clock stays high
        do_frame(8'hE0, 1'b0, 1'b0, 1'b0, "toE0");
        v0 = vcount;
        e0 = ecount;
        send_bits(11'b000_0000_1010, 4, 1'b0);
        n = 0;
        while (ecount == e0 && n < int'(TMO) + 200) begin
            wait_cyc(1);
            n++;
        end
        wait_cyc(5);
        check("timeout.nerr", 32'(ecount - e0), 32'd1);
        check("timeout.nvalid", 32'(vcount - v0), 32'd0);
        check("timeout.when",
              32'((ecyc - fall_cyc) >= int'(TMO) && (ecyc - fall_cyc) <= int'(TMO + FILT) + 8),
              32'd1);
        check_outputs("timeout");
        m_ext_p = 1'b0;
        m_brk_p = 1'b0;
        do_frame(8'h1C, 1'b0, 1'b0, 1'b0, "post_to");

        // Reset in the middle of a frame with a break prefix pending
        do_frame(8'hF0, 1'b0, 1'b0, 1'b0, "rsF0");
        e0 = ecount;
        send_bits(11'b000_0010_1100, 5, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(1);
            check($sformatf("midrst.outs%0d", i),
                  32'({scan_code, extended, make_break, valid, frame_err}), 32'h0);
        end
        reset = 1'b1;
        m_code  = 8'h00;
        m_ext_o = 1'b0;
        m_mb    = 1'b0;
        m_ext_p = 1'b0;
        m_brk_p = 1'b0;
        wait_cyc(20);
        check("midrst.nerr", 32'(ecount - e0), 32'd0);
        do_frame(8'h1C, 1'b0, 1'b0, 1'b0, "post_rst");

        check("exclusive", 32'(both), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_scan_receiver.md
PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal samples needed before the filtered PS/2 clock changes level.
REQ-002 Parameter TIMEOUT_CYCLES, default 75000 (1 ms at 75 MHz): maximum clk cycles allowed between falling edges inside a frame.
REQ-003 clk  input  1  system clock, 75 MHz; all logic SHALL be on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous.
REQ-006 ps2_dat  input  1  raw PS/2 data line, asynchronous.
REQ-007 scan_code  output  8  last non-prefix scan code received, held until the next one.
REQ-008 extended  output  1  1 if an E0 prefix preceded scan_code.
REQ-009 make_break  output  1  1 = make (key down), 0 = break (key up), for scan_code.
REQ-010 valid  output  1  one-cycle pulse when scan_code/extended/make_break update.
REQ-011 frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout failure.

Function
REQ-012 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer, with both flops reset to 1.
REQ-013 Glitch filter: the filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; pulses shorter than this SHALL be ignored.
REQ-014 Falling-edge detect: a one-cycle fall strobe SHALL assert when the filtered clock goes from 1 to 0.
REQ-015 On each fall strobe, the data bit SHALL be the synchronized ps2_dat value in that cycle.
REQ-016 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-017 IDLE on fall: data 0 -> DATA with bit counter 0; data 1 -> stay in IDLE, no error.
REQ-018 DATA on fall: shift the bit in LSB-first; after the 8th bit -> PARITY.
REQ-019 PARITY on fall: record parity_ok = (XOR of 8 data bits and the parity bit == 1), i.e. odd parity; -> STOP.
REQ-020 STOP on fall: data 1 and parity_ok -> one-cycle byte_ready with the byte; otherwise frame_err pulse; in both cases -> IDLE.
REQ-021 Timeout: in any state other than IDLE, a counter SHALL increment every cycle and clear on each fall strobe.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE, pulse frame_err, and emit no byte.
REQ-023 The timeout counter SHALL be held at 0 in IDLE and SHALL saturate rather than wrap.
REQ-024 Decoder, on byte_ready with byte 0xE0: set ext_pending; no valid.
REQ-025 Decoder, on byte_ready with byte 0xF0: set brk_pending; no valid.
REQ-026 Decoder, on byte_ready with any other byte: on the next clk, scan_code <= byte, extended <= ext_pending, make_break <= ~brk_pending, and valid pulses for exactly 1 cycle.
REQ-027 Both pending flags SHALL clear in the same cycle as the valid pulse.
REQ-028 A frame_err SHALL clear ext_pending and brk_pending; scan_code, extended and make_break SHALL hold.
REQ-029 Latency: valid SHALL assert exactly 2 clk after the cycle in which the stop-bit fall strobe is asserted.
REQ-030 Repeated prefixes (E0 E0, F0 F0) SHALL leave the flag set; prefix order E0 F0 and F0 E0 SHALL both decode identically.
REQ-031 valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-032 While reset = 0, on each clk: FSM -> IDLE; bit counter, timeout counter and pending flags -> 0; filtered clock -> 1.
REQ-033 While reset = 0, outputs: scan_code = 0x00, extended = 0, make_break = 0, valid = 0, frame_err = 0.
REQ-034 A reset asserted mid-frame SHALL discard the partial frame with no frame_err pulse.
REQ-035 After reset releases, the next frame SHALL be accepted only starting from a new start bit.

Verification
REQ-036 Make 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> single valid pulse; scan_code = 0x1C, extended = 0, make_break = 1.
REQ-037 Frames F0 then 1C -> exactly one valid, after the 2nd frame; scan_code = 0x1C, make_break = 0.
REQ-038 E0 75 -> scan_code = 0x75, extended = 1, make_break = 1.
REQ-039 E0 F0 75 -> scan_code = 0x75, extended = 1, make_break = 0; the following 1C -> extended = 0.
REQ-040 0x1C sent with parity bit 1 -> one frame_err pulse, no valid, outputs unchanged; the next good 0x29 -> valid with scan_code = 0x29.
REQ-041 Start bit plus 3 data bits, then clock held high -> frame_err at TIMEOUT_CYCLES; 3-cycle low glitches on ps2_clk produce no fall strobe; reset asserted mid-frame -> all outputs 0.
